// File: rtl/control_byte_sender_if.sv
// Request/byte-stream bundle between a host-side bridge, the byte sender and the control unit.
interface control_byte_sender_if #(
    parameter int unsigned n_blocks       = 256,
    parameter int unsigned reg_addr_width = 4,
    parameter int unsigned data_width     = 16,
    parameter int unsigned instr_width    = 32
);
    localparam int unsigned block_width = $clog2(n_blocks);

    logic                      req_valid;
    logic                      req_ready;
    logic [7:0]                req_cmd;
    logic [2:0]                req_fmt;
    logic [block_width-1:0]    req_block;
    logic [reg_addr_width-1:0] req_reg;
    logic [data_width-1:0]     req_data;
    logic [instr_width-1:0]    req_instr;
    logic [31:0]               req_delay;
    logic [7:0]                out_byte;
    logic                      out_ready;
    logic                      next;
    logic                      done;
    logic                      error;
    logic                      busy;

    // Requester / controller side
    modport master (
        output req_valid, req_cmd, req_fmt, req_block, req_reg, req_data, req_instr, req_delay, next,
        input  req_ready, out_byte, out_ready, done, error, busy
    );

    // Byte sender side
    modport slave (
        input  req_valid, req_cmd, req_fmt, req_block, req_reg, req_data, req_instr, req_delay, next,
        output req_ready, out_byte, out_ready, done, error, busy
    );
endinterface

// File: rtl/control_byte_sender.sv
// Serializes one structured controller request into the command byte frame,
// paced by the out_ready/next handshake with a one-cycle gap between bytes.
// n_blocks must be at least 2 so the block field has a nonzero width.
module control_byte_sender #(
    parameter int unsigned n_blocks       = 256,
    parameter int unsigned reg_addr_width = 4,
    parameter int unsigned data_width     = 16,
    parameter int unsigned instr_width    = 32,
    parameter int unsigned timeout_cycles = 65535
) (
    input logic                 clk,
    input logic                 reset,
    control_byte_sender_if.slave bus
);
    localparam int unsigned DB    = data_width / 8;
    localparam int unsigned IB    = instr_width / 8;
    localparam int unsigned L_CMD = 1;
    localparam int unsigned L_BI  = 2 + IB;
    localparam int unsigned L_BR  = 3 + DB;
    localparam int unsigned L_DA  = 1 + DB;
    localparam int unsigned L_DD  = 5 + DB;
    localparam int unsigned M1    = (L_BI > L_BR) ? L_BI : L_BR;
    localparam int unsigned MAXB  = (M1 > L_DD) ? M1 : L_DD;
    localparam int unsigned FW    = 8 * MAXB;
    localparam int unsigned IDX_W = $clog2(MAXB + 1);
    localparam bit          TO_EN = (timeout_cycles != 0);
    localparam logic [31:0] TO_LAST = 32'((timeout_cycles == 0) ? 0 : timeout_cycles - 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t           state;
    logic [FW-1:0]    frame;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] last_idx;
    logic [31:0]      tcnt;

    logic [FW-1:0]    frame_c;
    logic [IDX_W-1:0] last_c;
    logic             fmt_ok_c;
    logic [7:0]       blk8_c;
    logic [7:0]       reg8_c;

    // Left-aligned frame image and last byte index for the request on the bus
    always_comb begin
        frame_c  = '0;
        last_c   = '0;
        fmt_ok_c = 1'b1;
        blk8_c   = 8'(bus.req_block);
        reg8_c   = 8'(bus.req_reg);
        case (bus.req_fmt)
            3'd0: begin
                frame_c[FW-1 -: 8] = bus.req_cmd;
                last_c = IDX_W'(L_CMD - 1);
            end
            3'd1: begin
                frame_c[FW-1 -: 16 + instr_width] = {bus.req_cmd, blk8_c, bus.req_instr};
                last_c = IDX_W'(L_BI - 1);
            end
            3'd2: begin
                frame_c[FW-1 -: 24 + data_width] = {bus.req_cmd, blk8_c, reg8_c, bus.req_data};
                last_c = IDX_W'(L_BR - 1);
            end
            3'd3: begin
                frame_c[FW-1 -: 8 + data_width] = {bus.req_cmd, bus.req_data};
                last_c = IDX_W'(L_DA - 1);
            end
            3'd4: begin
                frame_c[FW-1 -: 40 + data_width] = {bus.req_cmd, bus.req_data, bus.req_delay};
                last_c = IDX_W'(L_DD - 1);
            end
            default: fmt_ok_c = 1'b0;
        endcase
    end

    // The byte on the wire is always the top byte of the shifting frame
    assign bus.out_byte = frame[FW-1 -: 8];

    // Frame sequencer: accept, send/wait for next, one-cycle gap, timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            frame         <= '0;
            idx           <= '0;
            last_idx      <= '0;
            tcnt          <= '0;
            bus.req_ready <= 1'b1;
            bus.busy      <= 1'b0;
            bus.out_ready <= 1'b0;
            bus.done      <= 1'b0;
            bus.error     <= 1'b0;
        end else begin
            bus.done  <= 1'b0;
            bus.error <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (fmt_ok_c) begin
                            state         <= SEND;
                            frame         <= frame_c;
                            last_idx      <= last_c;
                            idx           <= '0;
                            tcnt          <= '0;
                            bus.out_ready <= 1'b1;
                            bus.req_ready <= 1'b0;
                            bus.busy      <= 1'b1;
                        end else begin
                            bus.error <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (bus.next) begin
                        bus.out_ready <= 1'b0;
                        tcnt          <= '0;
                        if (idx == last_idx) begin
                            state         <= IDLE;
                            bus.done      <= 1'b1;
                            bus.req_ready <= 1'b1;
                            bus.busy      <= 1'b0;
                        end else begin
                            state <= GAP;
                            idx   <= idx + IDX_W'(1);
                            frame <= frame << 8;
                        end
                    end else if (TO_EN && (tcnt == TO_LAST)) begin
                        state         <= IDLE;
                        tcnt          <= '0;
                        bus.out_ready <= 1'b0;
                        bus.error     <= 1'b1;
                        bus.req_ready <= 1'b1;
                        bus.busy      <= 1'b0;
                    end else begin
                        tcnt <= tcnt + 32'd1;
                    end
                end
                GAP: begin
                    state         <= SEND;
                    bus.out_ready <= 1'b1;
                end
                default: begin
                    state         <= IDLE;
                    bus.out_ready <= 1'b0;
                    bus.req_ready <= 1'b1;
                    bus.busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_control_byte_sender.sv
// Directed bench for control_byte_sender: one default instance and one with an 8-cycle timeout.
module tb_control_byte_sender;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fails  = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;

    // Free-running cycle count for frame-length measurements
    always @(posedge clk) cyc <= cyc + 1;

    control_byte_sender_if bus ();
    control_byte_sender_if bus_to ();

    control_byte_sender u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    control_byte_sender #(.timeout_cycles(8)) u_to (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_to)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle starting at the current falling edge
    task automatic send_req(input logic [7:0] cmd, input logic [2:0] fmt, input logic [7:0] blk,
                            input logic [3:0] rg, input logic [15:0] data, input logic [31:0] instr,
                            input logic [31:0] delay);
        bus.req_cmd   = cmd;
        bus.req_fmt   = fmt;
        bus.req_block = blk;
        bus.req_reg   = rg;
        bus.req_data  = data;
        bus.req_instr = instr;
        bus.req_delay = delay;
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    // Expect byte now, return next one cycle later, check the drop (and done on the last byte)
    task automatic byte_step(input string tag, input logic [7:0] exp, input bit last, input bit gap_next);
        check({tag, "_rdy"}, 32'(bus.out_ready), 32'd1);
        check({tag, "_byte"}, 32'(bus.out_byte), 32'(exp));
        check({tag, "_busy"}, 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        check({tag, "_hold"}, 32'(bus.out_byte), 32'(exp));
        bus.next = 1'b1;
        @(negedge clk);
        bus.next = gap_next;
        check({tag, "_drop"}, 32'(bus.out_ready), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'(last));
        if (last) check({tag, "_reqrdy"}, 32'(bus.req_ready), 32'd1);
        if (!last) begin
            @(negedge clk);
            bus.next = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int hold_bad;
        int hc;

        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_cmd = '0; bus.req_fmt = '0; bus.req_block = '0;
        bus.req_reg = '0; bus.req_data = '0; bus.req_instr = '0; bus.req_delay = '0; bus.next = 1'b0;
        bus_to.req_valid = 1'b0; bus_to.req_cmd = '0; bus_to.req_fmt = '0; bus_to.req_block = '0;
        bus_to.req_reg = '0; bus_to.req_data = '0; bus_to.req_instr = '0; bus_to.req_delay = '0;
        bus_to.next = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_out_ready", 32'(bus.out_ready), 32'd0);
        check("rst_out_byte", 32'(bus.out_byte), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_error", 32'(bus.error), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // CMD_ONLY 0x05
        send_req(8'h05, 3'd0, 8'h00, 4'h0, 16'h0, 32'h0, 32'h0);
        byte_step("c1", 8'h05, 1'b1, 1'b0);
        @(negedge clk);
        check("c1_done_once", 32'(bus.done), 32'd0);

        // BLOCK_REG 02,07,03,BE,EF with 3L-1 = 14 cycle frame
        send_req(8'h02, 3'd2, 8'd7, 4'd3, 16'hBEEF, 32'h0, 32'h0);
        t0 = cyc;
        byte_step("br0", 8'h02, 1'b0, 1'b0);
        byte_step("br1", 8'h07, 1'b0, 1'b0);
        byte_step("br2", 8'h03, 1'b0, 1'b0);
        byte_step("br3", 8'hBE, 1'b0, 1'b0);
        byte_step("br4", 8'hEF, 1'b1, 1'b0);
        check("br_frame_cycles", 32'(cyc - t0), 32'd14);

        // DATA_DELAY, fields changed after accept must not leak into the frame
        send_req(8'h04, 3'd4, 8'h00, 4'h0, 16'h1234, 32'h0, 32'h00012C40);
        bus.req_cmd = 8'hAA; bus.req_data = 16'hFFFF; bus.req_delay = 32'hFFFFFFFF;
        byte_step("dd0", 8'h04, 1'b0, 1'b0);
        byte_step("dd1", 8'h12, 1'b0, 1'b0);
        byte_step("dd2", 8'h34, 1'b0, 1'b0);
        byte_step("dd3", 8'h00, 1'b0, 1'b0);
        byte_step("dd4", 8'h01, 1'b0, 1'b0);
        byte_step("dd5", 8'h2C, 1'b0, 1'b0);
        byte_step("dd6", 8'h40, 1'b1, 1'b0);
        @(negedge clk);
        check("dd_done_once", 32'(bus.done), 32'd0);

        // BLOCK_INSTR, next during a gap ignored, next withheld 100 cycles on A1
        send_req(8'h01, 3'd1, 8'h2A, 4'h0, 16'h0, 32'hA1B2C3D4, 32'h0);
        byte_step("bi0", 8'h01, 1'b0, 1'b1);
        byte_step("bi1", 8'h2A, 1'b0, 1'b0);
        hold_bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (!(bus.out_ready === 1'b1 && bus.out_byte === 8'hA1)) hold_bad++;
            @(negedge clk);
        end
        check("bi_hold100", 32'(hold_bad), 32'd0);
        byte_step("bi2", 8'hA1, 1'b0, 1'b0);
        byte_step("bi3", 8'hB2, 1'b0, 1'b0);
        byte_step("bi4", 8'hC3, 1'b0, 1'b0);
        byte_step("bi5", 8'hD4, 1'b1, 1'b0);
        @(negedge clk);

        // Bad format 6: error pulse only, no bytes
        send_req(8'h09, 3'd6, 8'h00, 4'h0, 16'h0, 32'h0, 32'h0);
        check("bad_error", 32'(bus.error), 32'd1);
        check("bad_out_ready", 32'(bus.out_ready), 32'd0);
        check("bad_req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        check("bad_error_once", 32'(bus.error), 32'd0);
        check("bad_out_ready2", 32'(bus.out_ready), 32'd0);
        // next while idle is ignored
        bus.next = 1'b1;
        @(negedge clk);
        bus.next = 1'b0;
        check("idle_next_rdy", 32'(bus.out_ready), 32'd0);
        check("idle_next_done", 32'(bus.done), 32'd0);

        // Reset during the gap of a BLOCK_REG frame
        send_req(8'h02, 3'd2, 8'd7, 4'd3, 16'hBEEF, 32'h0, 32'h0);
        check("rg_byte0", 32'(bus.out_byte), 32'h02);
        @(negedge clk);
        bus.next = 1'b1;
        @(negedge clk);
        bus.next = 1'b0;
        check("rg_in_gap", 32'(bus.out_ready), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rg_out_ready", 32'(bus.out_ready), 32'd0);
        check("rg_req_ready", 32'(bus.req_ready), 32'd1);
        check("rg_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        check("rg_done2", 32'(bus.done), 32'd0);
        check("rg_out_ready2", 32'(bus.out_ready), 32'd0);
        send_req(8'h33, 3'd0, 8'h00, 4'h0, 16'h0, 32'h0, 32'h0);
        byte_step("rg_c", 8'h33, 1'b1, 1'b0);
        @(negedge clk);

        // Timeout instance: out_ready high exactly 8 cycles, then error
        bus_to.req_cmd = 8'h77; bus_to.req_fmt = 3'd0; bus_to.req_valid = 1'b1;
        @(negedge clk);
        bus_to.req_valid = 1'b0;
        check("to_byte", 32'(bus_to.out_byte), 32'h77);
        hc = 0;
        while (bus_to.out_ready === 1'b1 && hc < 20) begin
            hc++;
            @(negedge clk);
        end
        check("to_ready_cycles", 32'(hc), 32'd8);
        check("to_error", 32'(bus_to.error), 32'd1);
        check("to_out_ready", 32'(bus_to.out_ready), 32'd0);
        check("to_req_ready", 32'(bus_to.req_ready), 32'd1);
        bus_to.req_cmd = 8'h78; bus_to.req_valid = 1'b1;
        @(negedge clk);
        bus_to.req_valid = 1'b0;
        check("to_new_rdy", 32'(bus_to.out_ready), 32'd1);
        check("to_new_byte", 32'(bus_to.out_byte), 32'h78);
        check("to_new_error", 32'(bus_to.error), 32'd0);
        @(negedge clk);
        bus_to.next = 1'b1;
        @(negedge clk);
        bus_to.next = 1'b0;
        check("to_new_done", 32'(bus_to.done), 32'd1);
        check("to_new_noerr", 32'(bus_to.error), 32'd0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
